// File: rtl/instr_issuer.sv
// Instruction front end: packs a 4-bit nibble stream into 12-bit PE words and checks each
// word's operand slots against the write slot. Legal words are queued in a FIFO for issue.
module instr_issuer #(
    parameter int DEPTH     = 8,
    parameter int NUM_SLOTS = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [3:0]                    nib_in,
    input  logic                          nib_valid,
    output logic                          nib_ready,
    input  logic                          abort,
    output logic [11:0]                   instr_out,
    output logic                          instr_valid,
    input  logic                          instr_ready,
    output logic [$clog2(NUM_SLOTS)-1:0]  slot,
    output logic                          prog_done,
    output logic [$clog2(DEPTH):0]        count,
    output logic                          fault,
    output logic [$clog2(NUM_SLOTS)-1:0]  fault_slot
);

    localparam int SLOT_W = $clog2(NUM_SLOTS);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int CMP_W  = (SLOT_W > 3) ? SLOT_W : 3;
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);

    typedef enum logic {RUN, FAULT} state_t;

    state_t              state, state_next;
    logic [1:0]          nib_cnt;
    logic [7:0]          part;
    logic [11:0]         mem [DEPTH];
    logic [PTR_W-1:0]    wptr, rptr;
    logic [CNT_W-1:0]    cnt;
    logic [SLOT_W-1:0]   wslot, rslot, fault_slot_q;
    logic                prog_done_q;
    logic                full, empty, accept, push, reject, pop;
    logic [11:0]         word;

    // A PE operand may only reference a slot already written earlier in the program.
    function automatic logic operand_ok(input logic use_imm, input logic [3:0] op,
                                        input logic [SLOT_W-1:0] ws);
        logic [CMP_W-1:0] idx;
        logic [CMP_W-1:0] lim;
        idx = CMP_W'(op[2:0]);
        lim = CMP_W'(ws);
        return use_imm | (!op[3] && (idx < lim));
    endfunction

    function automatic logic word_ok(input logic [11:0] w, input logic [SLOT_W-1:0] ws);
        return operand_ok(w[3], w[11:8], ws) & operand_ok(w[2], w[7:4], ws);
    endfunction

    assign full   = (cnt == FULL_CNT);
    assign empty  = (cnt == '0);
    assign word   = {part, nib_in};
    assign accept = nib_valid & nib_ready;
    assign pop    = instr_valid & instr_ready;

    always_comb begin
        state_next = state;
        nib_ready  = 1'b0;
        fault      = 1'b0;
        push       = 1'b0;
        reject     = 1'b0;
        case (state)
            RUN: begin
                nib_ready = (nib_cnt != 2'd2) | !full;
                if (nib_valid && nib_ready && (nib_cnt == 2'd2) && !abort) begin
                    if (word_ok(word, wslot)) begin
                        push = 1'b1;
                    end else begin
                        reject     = 1'b1;
                        state_next = FAULT;
                    end
                end
            end
            FAULT: begin
                fault = 1'b1;
                if (abort) state_next = RUN;
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= RUN;
        else       state <= state_next;
    end

    // Control state: reset and abort both return everything to the empty, slot-0 condition.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            nib_cnt      <= '0;
            wptr         <= '0;
            rptr         <= '0;
            cnt          <= '0;
            wslot        <= '0;
            rslot        <= '0;
            fault_slot_q <= '0;
            prog_done_q  <= 1'b0;
        end else if (abort) begin
            nib_cnt      <= '0;
            wptr         <= '0;
            rptr         <= '0;
            cnt          <= '0;
            wslot        <= '0;
            rslot        <= '0;
            fault_slot_q <= '0;
            prog_done_q  <= 1'b0;
        end else begin
            if (accept) nib_cnt <= (nib_cnt == 2'd2) ? 2'd0 : nib_cnt + 2'd1;
            if (push) begin
                wptr  <= wptr + PTR_W'(1);
                wslot <= (wslot == LAST_SLOT) ? '0 : wslot + SLOT_W'(1);
            end
            if (pop) begin
                rptr  <= rptr + PTR_W'(1);
                rslot <= (rslot == LAST_SLOT) ? '0 : rslot + SLOT_W'(1);
            end
            if (push && !pop)      cnt <= cnt + CNT_W'(1);
            else if (pop && !push) cnt <= cnt - CNT_W'(1);
            if (reject) fault_slot_q <= wslot;
            prog_done_q <= pop && (rslot == LAST_SLOT);
        end
    end

    // Datapath storage needs no reset: nib_cnt and the FIFO count gate its visibility.
    always_ff @(posedge clock) begin
        if (accept && nib_cnt == 2'd0) part[7:4] <= nib_in;
        if (accept && nib_cnt == 2'd1) part[3:0] <= nib_in;
        if (push) mem[wptr] <= word;
    end

    assign instr_valid = !empty;
    assign instr_out   = empty ? 12'h000 : mem[rptr];
    assign slot        = rslot;
    assign prog_done   = prog_done_q;
    assign count       = cnt;
    assign fault_slot  = fault_slot_q;

endmodule

// File: tb/tb_instr_issuer.sv
// Scoreboard bench for instr_issuer: stimulus queues expected {slot, word} pairs and a
// negedge monitor checks every issued word plus the prog_done pulse.
module tb_instr_issuer;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  nib_in;
    logic        nib_valid;
    logic        nib_ready;
    logic        abort;
    logic [11:0] instr_out;
    logic        instr_valid;
    logic        instr_ready;
    logic [2:0]  slot;
    logic        prog_done;
    logic [3:0]  count;
    logic        fault;
    logic [2:0]  fault_slot;

    int passed = 0;
    int total  = 0;
    int pd_cnt = 0;
    logic pd_exp = 1'b0;
    logic [2:0]  m_wslot = 3'd0;
    logic [14:0] exp_q[$];

    instr_issuer #(.DEPTH(8), .NUM_SLOTS(8)) dut (
        .clock(clock), .reset(reset), .nib_in(nib_in), .nib_valid(nib_valid),
        .nib_ready(nib_ready), .abort(abort), .instr_out(instr_out),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .slot(slot),
        .prog_done(prog_done), .count(count), .fault(fault), .fault_slot(fault_slot)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    // Monitor: every pop the DUT performs must match the front of the scoreboard.
    always @(negedge clock) begin
        if (reset) begin
            pd_exp = 1'b0;
        end else begin
            chk("prog_done", prog_done, pd_exp);
            if (prog_done) pd_cnt++;
            pd_exp = 1'b0;
            if (!abort && instr_valid && instr_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_issue: got word %0h with empty scoreboard", instr_out);
                end else begin
                    logic [14:0] e;
                    e = exp_q.pop_front();
                    chk("issue_word", instr_out, e[11:0]);
                    chk("issue_slot", slot, e[14:12]);
                    pd_exp = (slot == 3'd7);
                end
            end
        end
    end

    task automatic sync();
        @(posedge clock); #1;
    endtask

    task automatic send_nib(input logic [3:0] n);
        int waited = 0;
        nib_in = n;
        nib_valid = 1'b1;
        @(negedge clock);
        while (!nib_ready && waited < 50) begin
            @(negedge clock);
            waited++;
        end
        if (!nib_ready) begin
            total++;
            $display("FAIL nib_timeout: got nib_ready=0 for 50 cycles required 1");
        end
        sync();
        nib_valid = 1'b0;
    endtask

    task automatic send_word(input logic [11:0] w, input logic legal);
        if (legal) begin
            exp_q.push_back({m_wslot, w});
            m_wslot = m_wslot + 3'd1;
        end
        send_nib(w[11:8]);
        send_nib(w[7:4]);
        send_nib(w[3:0]);
    endtask

    task automatic do_abort();
        abort = 1'b1;
        exp_q.delete();
        m_wslot = 3'd0;
        sync();
        abort = 1'b0;
    endtask

    task automatic wait_empty();
        int n = 0;
        @(negedge clock);
        while (count != 0 && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (count != 0) begin
            total++;
            $display("FAIL drain_timeout: got count=%0d required 0", count);
        end
        sync();
    endtask

    initial begin
        reset = 1'b1; nib_in = 4'h0; nib_valid = 1'b0; abort = 1'b0; instr_ready = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_valid", instr_valid, 0);
        chk("rst_out", instr_out, 0);
        chk("rst_slot", slot, 0);
        chk("rst_count", count, 0);
        chk("rst_fault", fault, 0);
        chk("rst_fault_slot", fault_slot, 0);
        chk("rst_nib_ready", nib_ready, 1);
        chk("rst_prog_done", prog_done, 0);
        sync();
        reset = 1'b0;

        // T1: single word, 1-cycle latency, then pop
        send_word(12'h12C, 1'b1);
        @(negedge clock);
        chk("t1_valid", instr_valid, 1);
        chk("t1_out", instr_out, 12'h12C);
        chk("t1_slot", slot, 0);
        chk("t1_count", count, 1);
        sync(); instr_ready = 1'b1;
        sync(); instr_ready = 1'b0;
        @(negedge clock);
        chk("t1_count_after_pop", count, 0);
        chk("t1_valid_after_pop", instr_valid, 0);
        sync();

        // T2/T6: fill FIFO, stall the completing nibble, pop and retry
        do_abort();
        pd_cnt = 0;
        for (int i = 0; i < 8; i++) send_word(12'h10C + 12'(i) * 12'h110, 1'b1);
        @(negedge clock);
        chk("t2_count_full", count, 8);
        chk("t2_ready_first_nib", nib_ready, 1);
        sync();
        exp_q.push_back({m_wslot, 12'h9AC});
        m_wslot = m_wslot + 3'd1;
        send_nib(4'h9);
        send_nib(4'hA);
        nib_in = 4'hC; nib_valid = 1'b1;
        @(negedge clock);
        chk("t2_stall_full", nib_ready, 0);
        sync(); instr_ready = 1'b1;
        @(negedge clock);
        chk("t6_stall_with_pop", nib_ready, 0);
        chk("t6_count_before_pop", count, 8);
        sync(); instr_ready = 1'b0;
        @(negedge clock);
        chk("t6_count_after_pop", count, 7);
        chk("t6_ready_after_pop", nib_ready, 1);
        sync(); nib_valid = 1'b0;
        @(negedge clock);
        chk("t6_count_refill", count, 8);
        sync(); instr_ready = 1'b1;
        wait_empty();
        instr_ready = 1'b0;
        repeat (2) sync();
        chk("t2_prog_done_pulses", pd_cnt, 1);

        // T3: slot-ordering faults
        do_abort();
        send_word(12'h010, 1'b0);
        @(negedge clock);
        chk("t3_fault", fault, 1);
        chk("t3_fault_slot", fault_slot, 0);
        chk("t3_nib_ready", nib_ready, 0);
        chk("t3_count", count, 0);
        chk("t3_valid", instr_valid, 0);
        sync();
        do_abort();
        @(negedge clock);
        chk("t3_fault_cleared", fault, 0);
        chk("t3_ready_restored", nib_ready, 1);
        sync();
        send_word(12'h10C, 1'b1);
        send_word(12'h21C, 1'b1);
        send_word(12'h010, 1'b1);
        send_word(12'h804, 1'b0);
        @(negedge clock);
        chk("t3b_fault", fault, 1);
        chk("t3b_fault_slot", fault_slot, 3);
        chk("t3b_count", count, 3);
        sync(); instr_ready = 1'b1;
        wait_empty();
        instr_ready = 1'b0;
        chk("t3b_fault_sticky", fault, 1);

        // T4: back-to-back issue of 9 words
        do_abort();
        pd_cnt = 0;
        instr_ready = 1'b1;
        for (int i = 0; i < 9; i++) send_word(12'h20C + 12'(i) * 12'h100, 1'b1);
        wait_empty();
        instr_ready = 1'b0;
        repeat (2) sync();
        chk("t4_prog_done_pulses", pd_cnt, 1);

        // T5: abort after a partial word with words queued
        do_abort();
        for (int i = 0; i < 3; i++) send_word(12'h70C + 12'(i) * 12'h010, 1'b1);
        send_nib(4'hA);
        do_abort();
        @(negedge clock);
        chk("t5_count", count, 0);
        chk("t5_valid", instr_valid, 0);
        chk("t5_out", instr_out, 0);
        chk("t5_slot", slot, 0);
        chk("t5_nib_ready", nib_ready, 1);
        sync();
        send_word(12'h34C, 1'b1);
        @(negedge clock);
        chk("t5_clean_word", instr_out, 12'h34C);
        chk("t5_clean_slot", slot, 0);
        sync(); instr_ready = 1'b1;
        wait_empty();
        instr_ready = 1'b0;

        // Asynchronous reset mid-word
        send_nib(4'h5);
        #2 reset = 1'b1;
        exp_q.delete();
        m_wslot = 3'd0;
        sync();
        reset = 1'b0;
        send_word(12'h56C, 1'b1);
        @(negedge clock);
        chk("rst_mid_word", instr_out, 12'h56C);
        sync(); instr_ready = 1'b1;
        wait_empty();
        instr_ready = 1'b0;

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
